// File: rtl/admm_pkg.sv
// Shared types and default widths for the ADMM iteration sequencer and its phase blocks.
package admm_pkg;

    localparam int unsigned ADMM_MAX_ITER_W = 16;
    localparam int unsigned ADMM_RES_WIDTH  = 32;
    localparam int unsigned ADMM_TIMEOUT_W  = 20;
    localparam int unsigned NUM_PHASES      = 4;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_PRIMAL = 3'd1,
        PH_SLACK  = 3'd2,
        PH_DUAL   = 3'd3,
        PH_RESID  = 3'd4
    } phase_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_RELEASE = 3'd2,
        S_CHECK   = 3'd3,
        S_FINISH  = 3'd4
    } sched_state_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_PRIMAL: next_phase = PH_SLACK;
            PH_SLACK:  next_phase = PH_DUAL;
            PH_DUAL:   next_phase = PH_RESID;
            default:   next_phase = PH_PRIMAL;
        endcase
    endfunction

    // Bit 0 primal, 1 slack, 2 dual, 3 resid; idle selects nothing.
    function automatic logic [NUM_PHASES-1:0] phase_onehot(input phase_e p);
        case (p)
            PH_PRIMAL: phase_onehot = 4'b0001;
            PH_SLACK:  phase_onehot = 4'b0010;
            PH_DUAL:   phase_onehot = 4'b0100;
            PH_RESID:  phase_onehot = 4'b1000;
            default:   phase_onehot = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/admm_phase_hs.sv
// Generic start/done/release handshake with per-phase watchdog, shared by all four phases.
module admm_phase_hs
    import admm_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = ADMM_TIMEOUT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  phase_e                phase,
    input  logic                  active,
    input  logic                  releasing,
    input  logic [NUM_PHASES-1:0] done_vec,
    input  logic [TIMEOUT_W-1:0]  limit,
    output logic [NUM_PHASES-1:0] start_vec,
    output logic                  done_hit_c,
    output logic                  released_c,
    output logic                  expired_c
);

    logic [TIMEOUT_W-1:0] wdog;
    logic                 sel_done_c;

    // Done of the currently selected phase only.
    always_comb begin
        sel_done_c = 1'b0;
        case (phase)
            PH_PRIMAL: sel_done_c = done_vec[0];
            PH_SLACK:  sel_done_c = done_vec[1];
            PH_DUAL:   sel_done_c = done_vec[2];
            PH_RESID:  sel_done_c = done_vec[3];
            default:   sel_done_c = 1'b0;
        endcase
    end

    assign done_hit_c = active && sel_done_c;
    assign released_c = releasing && !sel_done_c;
    assign expired_c  = (active || releasing) && (wdog >= limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_vec <= '0;
            wdog      <= '0;
        end else begin
            if (active && !sel_done_c && !expired_c) begin
                start_vec <= phase_onehot(phase);
            end else begin
                start_vec <= '0;
            end
            // Counter spans RUN and RELEASE of one phase; restarts once done has fallen.
            if (!(active || releasing) || released_c) begin
                wdog <= '0;
            end else if (wdog != '1) begin
                wdog <= wdog + TIMEOUT_W'(1);
            end
        end
    end

endmodule

// File: rtl/admm_scheduler.sv
// ADMM iteration sequencer: runs primal/slack/dual/resid phases per iteration until convergence,
// iteration limit or watchdog expiry.
module admm_scheduler
    import admm_pkg::*;
#(
    parameter int unsigned MAX_ITER_W = ADMM_MAX_ITER_W,
    parameter int unsigned RES_WIDTH  = ADMM_RES_WIDTH,
    parameter int unsigned TIMEOUT_W  = ADMM_TIMEOUT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MAX_ITER_W-1:0] max_iter,
    input  logic [TIMEOUT_W-1:0]  phase_timeout,
    input  logic [RES_WIDTH-1:0]  tol_pri,
    input  logic [RES_WIDTH-1:0]  tol_dual,
    output logic                  primal_start,
    output logic                  slack_start,
    output logic                  dual_start,
    output logic                  resid_start,
    input  logic                  primal_done,
    input  logic                  slack_done,
    input  logic                  dual_done,
    input  logic                  resid_done,
    input  logic [RES_WIDTH-1:0]  primal_res,
    input  logic [RES_WIDTH-1:0]  dual_res,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic                  timeout_err,
    output logic [MAX_ITER_W-1:0] iter_count,
    output logic [2:0]            cur_phase
);

    sched_state_e          state;
    phase_e                phase;
    logic [MAX_ITER_W-1:0] max_iter_q;
    logic [TIMEOUT_W-1:0]  timeout_q;
    logic [RES_WIDTH-1:0]  tol_pri_q;
    logic [RES_WIDTH-1:0]  tol_dual_q;
    logic [RES_WIDTH-1:0]  pres_q;
    logic [RES_WIDTH-1:0]  dres_q;

    logic [NUM_PHASES-1:0] start_vec;
    logic                  done_hit_c;
    logic                  released_c;
    logic                  expired_c;

    admm_phase_hs #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_hs (
        .clk        (clk),
        .rst        (rst),
        .phase      (phase),
        .active     (state == S_RUN),
        .releasing  (state == S_RELEASE),
        .done_vec   ({resid_done, dual_done, slack_done, primal_done}),
        .limit      (timeout_q),
        .start_vec  (start_vec),
        .done_hit_c (done_hit_c),
        .released_c (released_c),
        .expired_c  (expired_c)
    );

    assign primal_start = start_vec[0];
    assign slack_start  = start_vec[1];
    assign dual_start   = start_vec[2];
    assign resid_start  = start_vec[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            phase       <= PH_IDLE;
            max_iter_q  <= '0;
            timeout_q   <= '0;
            tol_pri_q   <= '0;
            tol_dual_q  <= '0;
            pres_q      <= '0;
            dres_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            timeout_err <= 1'b0;
            iter_count  <= '0;
            cur_phase   <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        max_iter_q  <= max_iter;
                        timeout_q   <= phase_timeout;
                        tol_pri_q   <= tol_pri;
                        tol_dual_q  <= tol_dual;
                        iter_count  <= '0;
                        converged   <= 1'b0;
                        timeout_err <= 1'b0;
                        if (max_iter == '0) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            phase     <= PH_PRIMAL;
                            cur_phase <= PH_PRIMAL;
                            busy      <= 1'b1;
                        end
                    end
                end
                // A completion in the expiry cycle still counts as a completion.
                S_RUN: begin
                    if (done_hit_c) begin
                        if (phase == PH_RESID) begin
                            pres_q <= primal_res;
                            dres_q <= dual_res;
                        end
                        state <= S_RELEASE;
                    end else if (expired_c) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        cur_phase   <= 3'd0;
                        state       <= S_FINISH;
                    end
                end
                S_RELEASE: begin
                    if (released_c) begin
                        if (phase == PH_RESID) begin
                            cur_phase <= 3'd0;
                            state     <= S_CHECK;
                        end else begin
                            phase     <= next_phase(phase);
                            cur_phase <= next_phase(phase);
                            state     <= S_RUN;
                        end
                    end else if (expired_c) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        cur_phase   <= 3'd0;
                        state       <= S_FINISH;
                    end
                end
                S_CHECK: begin
                    iter_count <= iter_count + MAX_ITER_W'(1);
                    if ((pres_q <= tol_pri_q) && (dres_q <= tol_dual_q)) begin
                        converged <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_FINISH;
                    end else if ((iter_count + MAX_ITER_W'(1)) == max_iter_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        phase     <= PH_PRIMAL;
                        cur_phase <= PH_PRIMAL;
                        state     <= S_RUN;
                    end
                end
                S_FINISH: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
